// File: rtl/inst_seq_ctrl.sv
// Fetch/decode/issue sequencer; >=4-5 cycles per instruction, stalls on imem_ack, ex_ready and wb_done.
// WB_TIMEOUT_EN adds a 16-cycle writeback watchdog that sets sticky err and moves on.
module inst_seq_ctrl #(
    parameter int PROG_LEN = 8,
    parameter int PC_W     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [31:0]     ex_op,
    output logic [1:0]      ex_type,
    output logic [4:0]      ex_dest,
    input  logic            wb_done,
    output logic            busy,
    output logic            done,
    output logic            err,
    input  logic            sel,
    output logic [7:0]      led
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_WB, S_NEXT, S_DONE
    } state_t;

    localparam logic [1:0]      T_R     = 2'd0;
    localparam logic [1:0]      T_I     = 2'd1;
    localparam logic [1:0]      T_J     = 2'd2;
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [1:0]      r_type;
    logic [4:0]      r_dest;
    logic [2:0]      r_cnt_r;
    logic [2:0]      r_cnt_i;
    logic [2:0]      r_cnt_j;
    logic [1:0]      r_c3;
    logic [1:0]      r_c4;
    logic [1:0]      r_c5;
    logic [1:0]      r_c6;
    logic [7:0]      r_led;
    logic            w_start;
    logic            w_xfer;
    logic            w_wb_timeout;
    logic [5:0]      w_opcode;
    logic [1:0]      w_dec_type;
    logic [4:0]      w_dec_dest;
    logic            w_unused_j;

    assign w_start    = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_xfer     = (r_state == S_ISSUE) && ex_ready;
    assign w_opcode   = r_ir[31:26];
    assign w_unused_j = r_cnt_j[2];

    always_comb begin
        w_dec_type = T_I;
        w_dec_dest = r_ir[20:16];
        if (w_opcode == 6'd0) begin
            w_dec_type = T_R;
            w_dec_dest = r_ir[15:11];
        end else if (w_opcode == 6'd2 || w_opcode == 6'd3) begin
            w_dec_type = T_J;
            w_dec_dest = 5'd0;
        end
    end

    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        ex_valid = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                done = (r_state == S_DONE);
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) w_next = S_DECODE;
            end
            S_DECODE: w_next = S_ISSUE;
            S_ISSUE: begin
                ex_valid = 1'b1;
                if (ex_ready) w_next = (r_dest != 5'd0) ? S_WAIT_WB : S_NEXT;
            end
            S_WAIT_WB: begin
                if (wb_done || w_wb_timeout) w_next = S_NEXT;
            end
            S_NEXT: w_next = (r_pc == LAST_PC) ? S_DONE : S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_type  <= '0;
            r_dest  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start)
                r_pc <= '0;
            else if (r_state == S_NEXT && r_pc != LAST_PC)
                r_pc <= r_pc + 1'b1;
            if (r_state == S_FETCH && imem_ack)
                r_ir <= imem_data;
            if (r_state == S_DECODE) begin
                r_type <= w_dec_type;
                r_dest <= w_dec_dest;
            end
        end
    end

    // Tallies advance only on the issue handshake, never while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_r <= '0;
            r_cnt_i <= '0;
            r_cnt_j <= '0;
            r_c3    <= '0;
            r_c4    <= '0;
            r_c5    <= '0;
            r_c6    <= '0;
        end else if (w_start) begin
            r_cnt_r <= '0;
            r_cnt_i <= '0;
            r_cnt_j <= '0;
            r_c3    <= '0;
            r_c4    <= '0;
            r_c5    <= '0;
            r_c6    <= '0;
        end else if (w_xfer) begin
            case (r_type)
                T_R:     r_cnt_r <= r_cnt_r + 3'd1;
                T_J:     r_cnt_j <= r_cnt_j + 3'd1;
                default: r_cnt_i <= r_cnt_i + 3'd1;
            endcase
            case (r_dest)
                5'd3:    r_c3 <= r_c3 + 2'd1;
                5'd4:    r_c4 <= r_c4 + 2'd1;
                5'd5:    r_c5 <= r_c5 + 2'd1;
                5'd6:    r_c6 <= r_c6 + 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_led <= '0;
        else
            r_led <= sel ? {r_c6, r_c5, r_c4, r_c3} : {r_cnt_j[1:0], r_cnt_i, r_cnt_r};
    end

`ifdef WB_TIMEOUT_EN
    logic [3:0] r_wdog;
    logic       r_err;

    // Counter is zero on the first WAIT_WB cycle, so 4'hF marks the 16th.
    assign w_wb_timeout = (r_state == S_WAIT_WB) && !wb_done && (r_wdog == 4'hF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= (r_state == S_WAIT_WB) ? r_wdog + 4'd1 : 4'd0;
            if (w_start)
                r_err <= 1'b0;
            else if (w_wb_timeout)
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_wb_timeout = 1'b0;
    assign err          = 1'b0;
`endif

    assign imem_addr = r_pc;
    assign ex_op     = r_ir;
    assign ex_type   = r_type;
    assign ex_dest   = r_dest;
    assign led       = r_led;

endmodule

// File: doc/inst_seq_ctrl.md
Name: inst_seq_ctrl

Overview:
- Multi-cycle sequencer for the instruction-classification datapath.
- Fetches a fixed-length program from an external instruction memory using a req/ack handshake.
- Decodes each word into an R, I or J class and a destination register, issues it to the execution unit, and waits for writeback when a register is written.
- Keeps class and destination tallies and drives the 8-bit LED display, selected by `sel`.

Parameters:
- PROG_LEN, 8: number of instructions per run (2..2^PC_W).
- PC_W, 4: program counter / imem address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  32  instruction word.
- ex_valid  out  1  issue valid.
- ex_ready  in  1  execution unit accepts.
- ex_op  out  32  issued instruction.
- ex_type  out  2  0=R, 1=I, 2=J.
- ex_dest  out  5  destination register; 0 if none.
- wb_done  in  1  writeback of the issued instruction complete.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- err  out  1  sticky writeback timeout (see Optional Feature).
- sel  in  1  LED page select.
- led  out  8  registered display.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; pc=0.
  - Counters r,i,j (3b) and c3..c6 (2b) = 0.
  - All outputs = 0.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_WB, NEXT, DONE.
- IDLE / DONE:
  - On start=1: clear pc and all counters, clear done; next state FETCH.
  - start is ignored in every other state.
- FETCH:
  - imem_req=1, with imem_addr=pc held stable until imem_ack.
  - On the imem_ack cycle: capture imem_data into the instruction register; go to DECODE.
  - imem_data is ignored when imem_ack=0.
- DECODE (1 cycle):
  - opcode = op[31:26].
  - opcode 0: R-class, dest = op[15:11].
  - opcode 2 or 3: J-class, dest = 0.
  - Any other opcode: I-class, dest = op[20:16].
- ISSUE:
  - ex_valid=1; ex_op, ex_type and ex_dest are stable until the handshake.
  - Transfer occurs on the cycle with ex_valid & ex_ready.
  - On transfer: increment the class counter (r, i or j); if dest is 3..6, increment the matching c3..c6.
  - All counters wrap modulo their width.
  - ex_valid drops the cycle after transfer.
  - Next state: WAIT_WB if dest≠0, otherwise NEXT.
- WAIT_WB:
  - Wait for wb_done=1, then go to NEXT.
  - wb_done in any other state is ignored.
- NEXT:
  - If pc==PROG_LEN-1: state DONE, done=1.
  - Otherwise pc=pc+1 and state FETCH.
  - J-class does not redirect pc; execution is purely sequential.
- busy=1 in every state except IDLE and DONE.
- led, updated every cycle (live during the run):
  - sel=0: led = {j[1:0], i, r}.
  - sel=1: led = {c6, c5, c4, c3}.
- rst asserted mid-run (any state) aborts the run immediately to the reset values; in-flight req/valid drop in the same cycle.
- Minimum latency per instruction, with ack/ready/wb_done zero-wait: FETCH 1 + DECODE 1 + ISSUE 1 + WAIT_WB 1 (if dest≠0) + NEXT 1.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - A 4-bit watchdog clears on entry to WAIT_WB and counts each cycle spent there.
  - If 16 cycles elapse without wb_done: set err=1 (sticky until rst or start) and advance to NEXT.
- Not defined:
  - WAIT_WB waits indefinitely.
  - err is tied to 0.

Test Plan:
- Load 8 words (0x20043456, 0x2005FFFF, 0x00A43020, 0x20030007, 0x00663004, 0x00031842, 0x8C859ABC, 0x08123456); zero-wait handshakes; start → done=1; led=0x63 with sel=0, led=0xA6 with sel=1.
- imem_ack delayed 3 cycles on word 0 → imem_req and imem_addr=0 held steady for 4 cycles; captured word is the one present on the ack cycle.
- ex_ready low for 5 cycles at word 2 → ex_valid, ex_op=0x00A43020, ex_dest=6 held; r increments once, only at the handshake.
- J word 0x08123456 → ex_type=2, ex_dest=0; NEXT follows ISSUE directly with no WAIT_WB; a stray wb_done has no effect.
- rst pulse while in WAIT_WB at pc=3 → all outputs and counters 0, state IDLE; a new start reruns from pc=0 and yields led=0x63.
- WB_TIMEOUT_EN defined, wb_done never asserted for word 0 → err=1 after 16 cycles in WAIT_WB, and the run still completes with done=1.
